// File: rtl/controle_multiciclo_pkg.sv
// ============================================================================
// controle_pkg : states, opcode/funct values, ula codes and mux encodings
// Revision     : 1.0
// ============================================================================
`default_nettype none

package controle_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_R_WB      = 4'd8,
    S_EXEC_I    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;
  localparam logic [3:0] ALU_SLLV = 4'b1100;
  localparam logic [3:0] ALU_SRLV = 4'b1101;
  localparam logic [3:0] ALU_SRAV = 4'b1110;
  localparam logic [3:0] ALU_SRA  = 4'b1111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/ula_controle.sv
// ============================================================================
// ula_controle : maps R-type funct or I-type opcode to the ula operation code
// Revision     : 1.0
// ============================================================================
`default_nettype none

module ula_controle
  import controle_pkg::*;
(
  input  logic       is_rtype,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       ext_zero,
  output logic       legal
);

  always_comb begin
    alu_control = ALU_ADD;
    ext_zero    = 1'b0;
    legal       = 1'b1;
    if (is_rtype) begin
      case (funct)
        FN_ADD, FN_ADDU: alu_control = ALU_ADD;
        FN_SUB, FN_SUBU: alu_control = ALU_SUB;
        FN_AND:          alu_control = ALU_AND;
        FN_OR:           alu_control = ALU_OR;
        FN_XOR:          alu_control = ALU_XOR;
        FN_NOR:          alu_control = ALU_NOR;
        FN_SLT:          alu_control = ALU_SLT;
        FN_SLTU:         alu_control = ALU_SLTU;
        FN_SLL:          alu_control = ALU_SLL;
        FN_SRL:          alu_control = ALU_SRL;
        FN_SRA:          alu_control = ALU_SRA;
        FN_SLLV:         alu_control = ALU_SLLV;
        FN_SRLV:         alu_control = ALU_SRLV;
        FN_SRAV:         alu_control = ALU_SRAV;
        default:         legal       = 1'b0;
      endcase
    end else begin
      // Only the immediate ALU group is legal here; memory/branch/jump
      // opcodes are recognised by the sequencer before this result is used.
      case (opcode)
        OP_ADDI, OP_ADDIU: alu_control = ALU_ADD;
        OP_SLTI:           alu_control = ALU_SLT;
        OP_SLTIU:          alu_control = ALU_SLTU;
        OP_ANDI: begin
          alu_control = ALU_AND;
          ext_zero    = 1'b1;
        end
        OP_ORI: begin
          alu_control = ALU_OR;
          ext_zero    = 1'b1;
        end
        OP_XORI: begin
          alu_control = ALU_XOR;
          ext_zero    = 1'b1;
        end
        OP_LUI:            alu_control = ALU_LUI;
        default:           legal       = 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/controle_multiciclo.sv
// ============================================================================
// controle_multiciclo : multicycle MIPS control FSM sequencing the shared datapath
// Revision            : 1.0
// ============================================================================
`default_nettype none

module controle_multiciclo
  import controle_pkg::*;
#(
  parameter int PC_INC = 4
)(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       ext_zero,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [3:0] alu_control,
  output logic       instr_done,
  output logic       illegal
);

  // The increment is fixed by the SRCB_FOUR datapath constant; PC_INC is descriptive only.
  if (PC_INC != 4) begin : g_pc_inc_descriptive
  end

  state_t     state;
  state_t     next_state;
  logic [5:0] op_q;
  logic [5:0] fn_q;
  logic [5:0] dec_op;
  logic [5:0] dec_fn;
  logic [3:0] dec_alu;
  logic       dec_ext_zero;
  logic       dec_legal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      op_q  <= 6'd0;
      fn_q  <= 6'd0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) begin
        op_q <= opcode;
        fn_q <= funct;
      end
    end
  end

  // Live IR fields drive dispatch in DECODE; later states use the latched copy.
  assign dec_op = (state == S_DECODE) ? opcode : op_q;
  assign dec_fn = (state == S_DECODE) ? funct  : fn_q;

  ula_controle u_ula_controle (
    .is_rtype    (dec_op == OP_RTYPE),
    .opcode      (dec_op),
    .funct       (dec_fn),
    .alu_control (dec_alu),
    .ext_zero    (dec_ext_zero),
    .legal       (dec_legal)
  );

  always_comb begin
    next_state  = state;
    pc_en       = 1'b0;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    ext_zero    = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REG;
    pc_source   = PCSRC_ALU;
    alu_control = ALU_ADD;
    instr_done  = 1'b0;
    illegal     = 1'b0;

    case (state)
      S_IDLE: next_state = S_FETCH;

      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) next_state = S_DECODE;
      end

      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW:   next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE: next_state = S_BRANCH;
          OP_J:           next_state = S_JUMP;
          OP_RTYPE: begin
            next_state = dec_legal ? S_EXEC_R : S_FETCH;
            illegal    = !dec_legal;
          end
          default: begin
            next_state = dec_legal ? S_EXEC_I : S_FETCH;
            illegal    = !dec_legal;
          end
        endcase
      end

      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        next_state = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end

      S_MEM_READ: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) next_state = S_MEM_WB;
      end

      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end

      S_MEM_WRITE: begin
        i_or_d     = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) next_state = S_FETCH;
      end

      S_EXEC_R: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_REG;
        alu_control = dec_alu;
        next_state  = S_R_WB;
      end

      S_R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end

      S_EXEC_I: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_IMM;
        alu_control = dec_alu;
        ext_zero    = dec_ext_zero;
        next_state  = S_I_WB;
      end

      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_REG;
        alu_control = ALU_SUB;
        pc_source   = PCSRC_ALUOUT;
        pc_en       = zero ^ (op_q == OP_BNE);
        instr_done  = 1'b1;
        next_state  = S_FETCH;
      end

      S_JUMP: begin
        pc_source  = PCSRC_JUMP;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end

      default: next_state = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire
